// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps up to BUF_DEPTH word fetches in flight and queues the results in order (1-cycle response-to-out latency).
// Issue stalls when the queue is full and not draining in the same cycle; define IFU_PERF_EN to add fetch/flush/drop counters.
module inst_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           BUF_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  cpu_rst_n,
  input  logic                  cpu_en,
  output logic                  inst_ren,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_gnt,
  input  logic                  inst_rvalid,
  input  logic [31:0]           inst_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  out_valid,
  output logic [31:0]           out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_drop_cnt
`endif
);

  localparam int unsigned   PW      = $clog2(BUF_DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] slot_pc   [BUF_DEPTH];
  logic [31:0]           slot_inst [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  slot_filled;
  logic [PW-1:0]         alloc_ptr;
  logic [PW-1:0]         fill_ptr;
  logic [PW-1:0]         head_ptr;
  logic [CW-1:0]         alloc_cnt;
  logic [CW-1:0]         pend_cnt;
  logic [CW-1:0]         drop_cnt;

  logic                  out_xfer;
  logic                  grant;
  logic                  rsp_keep;
  logic                  rsp_drop;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  assign out_valid   = slot_filled[head_ptr] & (alloc_cnt != '0);
  assign out_inst    = slot_inst[head_ptr];
  assign out_pc      = slot_pc[head_ptr];
  assign out_xfer    = out_valid & out_ready;

  // A full queue may still issue when its head drains in the same cycle.
  assign inst_ren    = cpu_rst_n & cpu_en & ~redirect_valid
                     & ((alloc_cnt < DEPTH_C) | out_xfer);
  assign inst_addr   = fetch_pc;
  assign grant       = inst_ren & inst_gnt;

  assign rsp_drop    = inst_rvalid & (drop_cnt != '0);
  assign rsp_keep    = inst_rvalid & (drop_cnt == '0);
  assign redirect_pc = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!cpu_rst_n) begin
      fetch_pc    <= RESET_PC;
      slot_pc     <= '{default: RESET_PC};
      slot_inst   <= '{default: 32'h0};
      slot_filled <= '0;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      alloc_cnt   <= '0;
      pend_cnt    <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      slot_filled <= '0;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      alloc_cnt   <= '0;
      pend_cnt    <= '0;
      // Every outstanding request except the one answered this cycle must be discarded.
      drop_cnt    <= drop_cnt + pend_cnt - CW'(inst_rvalid);
    end else begin
      if (grant) begin
        slot_pc[alloc_ptr]     <= fetch_pc;
        slot_filled[alloc_ptr] <= 1'b0;
        alloc_ptr              <= alloc_ptr + PW'(1);
        fetch_pc               <= fetch_pc + ADDR_WIDTH'(4);
      end
      if (rsp_keep) begin
        slot_inst[fill_ptr]    <= inst_data;
        slot_filled[fill_ptr]  <= 1'b1;
        fill_ptr               <= fill_ptr + PW'(1);
      end
      if (out_xfer) begin
        slot_filled[head_ptr]  <= 1'b0;
        head_ptr               <= head_ptr + PW'(1);
      end
      if (rsp_drop) begin
        drop_cnt               <= drop_cnt - CW'(1);
      end
      alloc_cnt <= alloc_cnt + CW'(grant) - CW'(out_xfer);
      pend_cnt  <= pend_cnt + CW'(grant) - CW'(rsp_keep);
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (!cpu_rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(out_xfer);
      perf_flush_cnt <= perf_flush_cnt + 32'(redirect_valid);
      perf_drop_cnt  <= perf_drop_cnt + 32'(rsp_drop);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: randomized memory and decode against an epoch-tagged stream model.
module tb_inst_fetch_unit;
  localparam int              AW  = 32;
  localparam int              D   = 4;
  localparam logic [AW-1:0]   RPC = '0;

  logic          clk = 1'b0;
  logic          cpu_rst_n;
  logic          cpu_en;
  logic          inst_ren;
  logic [AW-1:0] inst_addr;
  logic          inst_gnt;
  logic          inst_rvalid;
  logic [31:0]   inst_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          out_valid;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_pc;
  logic          out_ready;
`ifdef IFU_PERF_EN
  logic [31:0]   perf_fetch_cnt;
  logic [31:0]   perf_flush_cnt;
  logic [31:0]   perf_drop_cnt;
`endif

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_WIDTH(AW), .BUF_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_data(inst_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready)
`ifdef IFU_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  typedef struct { logic [AW-1:0] pc; int epoch; int gcyc; } req_t;

  req_t          mq[$];      // requests granted by memory, not yet answered
  logic [AW-1:0] buf_q[$];   // answered current-epoch PCs awaiting decode
  logic [AW-1:0] seen[$];    // PCs decode actually accepted
  logic [AW-1:0] m_pc;
  int            epoch = 0;
  int            cyc = 0;
  int            m_fetch = 0, m_flush = 0, m_drop = 0;
  int            gnt_pct = 100, rsp_pct = 100;
  int            obs_gnt = 0, first_ov = -1;
  logic          last_ren, last_ov;
  logic [AW-1:0] last_addr;
  int            n_assert = 0, n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h0001_0003) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with decode/control inputs already set; returns at the next posedge+1.
  task automatic cycle();
    int   live;
    logic exp_ov, exp_xfer, exp_ren;
    req_t r;
    inst_gnt = (mq.size() < D) && ($urandom_range(99) < gnt_pct);
    if (mq.size() > 0 && mq[0].gcyc < cyc && $urandom_range(99) < rsp_pct) begin
      inst_rvalid = 1'b1;
      inst_data   = mem_word(mq[0].pc);
    end else begin
      inst_rvalid = 1'b0;
      inst_data   = $urandom;
    end
    #3;
    live = 0;
    foreach (mq[i]) if (mq[i].epoch == epoch) live++;
    exp_ov   = buf_q.size() > 0;
    exp_xfer = exp_ov && out_ready;
    exp_ren  = cpu_en && !redirect_valid && ((buf_q.size() + live < D) || exp_xfer);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      check("out_pc", out_pc, buf_q[0]);
      check("out_inst", out_inst, mem_word(buf_q[0]));
    end
    check("inst_ren", inst_ren, exp_ren);
    if (exp_ren) check("inst_addr", inst_addr, m_pc);
`ifdef IFU_PERF_EN
    check("perf_fetch", perf_fetch_cnt, m_fetch);
    check("perf_flush", perf_flush_cnt, m_flush);
    check("perf_drop", perf_drop_cnt, m_drop);
`endif
    last_ren = inst_ren; last_ov = out_valid; last_addr = inst_addr;
    if (inst_ren && inst_gnt) obs_gnt++;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid && out_ready) seen.push_back(out_pc);
    if (exp_xfer) begin
      void'(buf_q.pop_front());
      m_fetch++;
    end
    if (inst_rvalid) begin
      r = mq.pop_front();
      if (r.epoch == epoch) buf_q.push_back(r.pc);
      else m_drop++;
    end
    if (exp_ren && inst_gnt) begin
      mq.push_back('{pc: m_pc, epoch: epoch, gcyc: cyc});
      m_pc = m_pc + 4;
    end
    if (redirect_valid) begin
      buf_q.delete();
      epoch++;
      m_pc = {redirect_addr[AW-1:2], 2'b00};
      m_flush++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    cpu_rst_n = 1'b0; inst_gnt = 1'b0; inst_rvalid = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_inst_ren", inst_ren, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_inst_addr", inst_addr, RPC);
    check("rst_out_pc", out_pc, RPC);
    check("rst_out_inst", out_inst, 32'h0);
`ifdef IFU_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rst_perf_flush", perf_flush_cnt, 32'h0);
    check("rst_perf_drop", perf_drop_cnt, 32'h0);
`endif
    mq.delete(); buf_q.delete(); seen.delete();
    m_pc = RPC; epoch++; m_fetch = 0; m_flush = 0; m_drop = 0;
    obs_gnt = 0; first_ov = -1;
    cpu_rst_n = 1'b1; cyc = 1;
  endtask

  initial begin
    cpu_rst_n = 1'b0; cpu_en = 1'b1; inst_gnt = 1'b0; inst_rvalid = 1'b0; inst_data = '0;
    redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b1;
    @(posedge clk); #1;

    // Straight-line fetch at one instruction per cycle.
    do_reset();
    gnt_pct = 100; rsp_pct = 100;
    run(20);
    check("first_ov_cycle", first_ov, 3);
    check("straight_cnt", seen.size(), 18);
    if (seen.size() == 18) begin
      check("straight_first", seen[0], 32'h0);
      check("straight_last", seen[17], 32'd68);
    end

    // Back-pressure: decode stalled, then released.
    do_reset();
    out_ready = 1'b0;
    run(10);
    check("bp_grants", obs_gnt, 4);
    check("bp_ren_stalled", last_ren, 1'b0);
    out_ready = 1'b1;
    cycle();
    check("bp_ren_resume", last_ren, 1'b1);
    run(9);
    check("bp_cnt", seen.size(), 10);
    if (seen.size() == 10) check("bp_last", seen[9], 32'd36);

    // Redirect with three unfilled requests; low address bits ignored.
    do_reset();
    rsp_pct = 0;
    run(3);
    redirect_valid = 1'b1; redirect_addr = 32'h403;
    cycle();
    redirect_valid = 1'b0; rsp_pct = 100;
    cycle();
    check("redir_addr", last_addr, 32'h400);
    check("redir_ov", last_ov, 1'b0);
    run(11);
    check("redir_cnt", seen.size(), 8);
    if (seen.size() > 0) check("redir_first", seen[0], 32'h400);
`ifdef IFU_PERF_EN
    check("redir_drops", perf_drop_cnt, 32'd3);
`endif

    // Redirect coinciding with a response and an offered grant.
    do_reset();
    rsp_pct = 0;
    run(3);
    rsp_pct = 100; redirect_valid = 1'b1; redirect_addr = 32'h800;
    cycle();
    redirect_valid = 1'b0;
    run(10);
    check("coinc_cnt", seen.size(), 7);
    if (seen.size() > 0) check("coinc_first", seen[0], 32'h800);
`ifdef IFU_PERF_EN
    check("coinc_drops", perf_drop_cnt, 32'd2);
`endif

    // PC wrap-around at the top of the address space.
    redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    seen.delete();
    run(8);
    if (seen.size() >= 2) begin
      check("wrap_pc0", seen[0], 32'hFFFF_FFFC);
      check("wrap_pc1", seen[1], 32'h0);
    end else begin
      check("wrap_cnt", seen.size(), 2);
    end

    // Reset with a full queue.
    out_ready = 1'b0;
    run(8);
    check("full_ov", last_ov, 1'b1);
    check("full_ren", last_ren, 1'b0);
    do_reset();
    out_ready = 1'b1;
    run(4);

    // Randomized traffic.
    gnt_pct = 70; rsp_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      out_ready      = ($urandom_range(3) != 0);
      cpu_en         = ($urandom_range(15) != 0);
      redirect_valid = ($urandom_range(31) == 0);
      redirect_addr  = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
